// File: rtl/xmit_pkg.sv
// Shared definitions for the framed serial link (rcvr/xmit): header byte,
// frame geometry, FSM state encoding and the header sanity check.
package xmit_pkg;

  localparam logic [7:0] DEFAULT_MATCH = 8'hA5;
  localparam int         FRAME_BITS    = 16;
  localparam int         HEAD_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_e;

  // A header is usable if it differs from the idle line and no proper prefix,
  // padded with zeros or ones from the top, reproduces it (no self-overlap
  // when the receiver re-arms mid-stream).
  function automatic bit match_ok(input logic [7:0] m, input logic idle);
    logic [7:0] ones;
    ones = 8'hFF;
    if (m == {8{idle}}) return 1'b0;
    for (int k = 1; k < 8; k++) begin
      if ((m >> k) == m) return 1'b0;
      if (((m >> k) | ~(ones >> k)) == m) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/xmit.sv
// Framed serial transmitter: one-deep holding register feeding a 16-bit
// MSB-first shifter (header MATCH then data byte); idle level between frames.
module xmit
  import xmit_pkg::*;
#(
  parameter logic [7:0] MATCH    = DEFAULT_MATCH,
  parameter logic       IDLE_BIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       writing,
  output logic       full,
  output logic       busy,
  output logic       overrun,
  output logic       data_out
);

  if (!match_ok(MATCH, IDLE_BIT)) begin : g_bad_match
    $error("xmit: MATCH header is unusable against IDLE_BIT");
  end

  state_e      state_q;
  logic [3:0]  count_q;
  logic [15:0] shift_q;
  logic [7:0]  hold_q;
  logic        full_q;
  logic        busy_q;
  logic        overrun_q;
  logic        dout_q;

  logic        wr_accept;
  logic        wr_reject;
  logic        last_bit;

  // Writes are judged on the registered full, so a write in the cycle the
  // FSM empties hold is still rejected.
  assign wr_accept = writing && !full_q;
  assign wr_reject = writing && full_q;
  assign last_bit  = (count_q == 4'(FRAME_BITS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      shift_q   <= 16'd0;
      hold_q    <= 8'd0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      dout_q    <= IDLE_BIT;
    end else begin
      if (wr_accept) begin
        hold_q    <= data_in;
        full_q    <= 1'b1;
        overrun_q <= 1'b0;
      end else if (wr_reject) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          dout_q <= IDLE_BIT;
          if (full_q) begin
            shift_q <= {MATCH, hold_q};
            full_q  <= 1'b0;
            count_q <= 4'd0;
            dout_q  <= MATCH[7];
            state_q <= HEAD;
            busy_q  <= 1'b1;
          end
        end
        HEAD, BODY: begin
          if (last_bit) begin
            if (full_q) begin
              // Refilled in time: chain the next frame with no gap.
              shift_q <= {MATCH, hold_q};
              full_q  <= 1'b0;
              count_q <= 4'd0;
              dout_q  <= MATCH[7];
              state_q <= HEAD;
              busy_q  <= 1'b1;
            end else begin
              count_q <= 4'd0;
              dout_q  <= IDLE_BIT;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            dout_q  <= shift_q[14];
            shift_q <= {shift_q[14:0], 1'b0};
            count_q <= count_q + 4'd1;
            if (count_q == 4'(HEAD_BITS - 1)) state_q <= BODY;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          dout_q  <= IDLE_BIT;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_xmit.sv
// Directed bench for xmit: bit-exact frame checks plus a behavioural receiver
// on data_out that extracts header-matched bytes.
module tb_xmit;

  localparam logic [7:0] MATCH = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       writing = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       full, busy, overrun, data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  xmit #(.MATCH(MATCH), .IDLE_BIT(1'b0)) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .writing (writing),
    .full    (full),
    .busy    (busy),
    .overrun (overrun),
    .data_out(data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Receiver model: slide an 8-bit window until it equals MATCH, take the
  // next 8 bits as data, then clear the window and search again.
  logic [7:0] rx_win  = 8'd0;
  logic [7:0] rx_body = 8'd0;
  bit         rx_in_body = 1'b0;
  int         rx_nb = 0;
  logic [7:0] rx_dat[$];
  int         rx_cyc[$];

  always @(negedge clock) begin
    if (reset) begin
      rx_win     = 8'd0;
      rx_in_body = 1'b0;
      rx_nb      = 0;
    end else if (!rx_in_body) begin
      rx_win = {rx_win[6:0], data_out};
      if (rx_win == MATCH) begin
        rx_in_body = 1'b1;
        rx_nb      = 0;
      end
    end else begin
      rx_body = {rx_body[6:0], data_out};
      rx_nb++;
      if (rx_nb == 8) begin
        rx_dat.push_back(rx_body);
        rx_cyc.push_back(cyc);
        rx_in_body = 1'b0;
        rx_win     = 8'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_dout", data_out, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  // Checks frame bits start..15, optionally issuing a one-cycle write
  // before the edge following bit index wr_idx.
  task automatic frame_chk(input logic [7:0] b, input int start,
                           input int wr_idx, input logic [7:0] wr_dat);
    logic [15:0] f;
    f = {MATCH, b};
    for (int i = start; i < 16; i++) begin
      @(negedge clock);
      chk("frame_bit", data_out, f[15-i]);
      chk("frame_busy", busy, 1);
      if (i == wr_idx) begin
        writing = 1'b1;
        data_in = wr_dat;
      end else if (i == wr_idx + 1) begin
        writing = 1'b0;
      end
    end
  endtask

  task automatic write_start(input logic [7:0] b);
    @(negedge clock);
    writing = 1'b1;
    data_in = b;
    @(negedge clock);
    writing = 1'b0;
    chk("wr_full", full, 1);
    chk("wr_busy", busy, 0);
    chk("wr_dout", data_out, 0);
  endtask

  initial begin
    int d;

    // Reset and idle line
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("rst_dout", data_out, 0);
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
    end

    // Single frame 3C
    write_start(8'h3C);
    frame_chk(8'h3C, 0, -1, 8'h00);
    idle_chk(3);
    chk("rx3c_n", rx_dat.size(), 1);
    if (rx_dat.size() >= 1) chk("rx3c_dat", rx_dat[0], 8'h3C);
    rx_dat.delete(); rx_cyc.delete();

    // Back-to-back 00 then FF, second write mid-frame
    write_start(8'h00);
    frame_chk(8'h00, 0, 0, 8'hFF);
    frame_chk(8'hFF, 0, -1, 8'h00);
    idle_chk(3);
    chk("rxb2b_n", rx_dat.size(), 2);
    if (rx_dat.size() >= 2) begin
      chk("rxb2b_d0", rx_dat[0], 8'h00);
      chk("rxb2b_d1", rx_dat[1], 8'hFF);
      d = rx_cyc[1] - rx_cyc[0];
      chk("rxb2b_gap", d, 16);
    end
    rx_dat.delete(); rx_cyc.delete();

    // Consecutive writes 11, 22, 33: 22 rejected, overrun set then cleared
    @(negedge clock);
    writing = 1'b1; data_in = 8'h11;
    @(negedge clock);
    chk("ovr_full_t", full, 1);
    chk("ovr_flag_t", overrun, 0);
    data_in = 8'h22;
    @(negedge clock);
    chk("ovr_flag_t1", overrun, 1);
    chk("ovr_full_t1", full, 0);
    chk("ovr_bit0", data_out, 1);
    data_in = 8'h33;
    @(negedge clock);
    writing = 1'b0;
    chk("ovr_full_t2", full, 1);
    chk("ovr_flag_t2", overrun, 0);
    chk("ovr_bit1", data_out, 0);
    frame_chk(8'h11, 2, -1, 8'h00);
    frame_chk(8'h33, 0, -1, 8'h00);
    idle_chk(3);
    chk("rxovr_n", rx_dat.size(), 2);
    if (rx_dat.size() >= 2) begin
      chk("rxovr_d0", rx_dat[0], 8'h11);
      chk("rxovr_d1", rx_dat[1], 8'h33);
    end
    rx_dat.delete(); rx_cyc.delete();

    // Body equal to header, long idle tail
    write_start(8'hA5);
    frame_chk(8'hA5, 0, -1, 8'h00);
    idle_chk(20);
    chk("rxa5_n", rx_dat.size(), 1);
    if (rx_dat.size() >= 1) chk("rxa5_dat", rx_dat[0], 8'hA5);
    rx_dat.delete(); rx_cyc.delete();

    // Reset mid-frame with hold occupied
    write_start(8'h77);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("trunc_bit", data_out, {MATCH, 8'h77} >> (15 - i) & 16'h1);
      if (i == 0) begin writing = 1'b1; data_in = 8'hC3; end
      else writing = 1'b0;
    end
    chk("trunc_full", full, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_dout", data_out, 0);
    chk("mrst_full", full, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovr", overrun, 0);
    @(negedge clock);
    reset = 1'b0;
    idle_chk(5);
    chk("mrst_rx_n", rx_dat.size(), 0);
    write_start(8'h5A);
    frame_chk(8'h5A, 0, -1, 8'h00);
    idle_chk(3);
    chk("rx5a_n", rx_dat.size(), 1);
    if (rx_dat.size() >= 1) chk("rx5a_dat", rx_dat[0], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
